iterative_multiplier: RTL and testbench

//   Multi-cycle shift-add multiplier for the execute stage, one operand bit per cycle.

---
 rtl/iterative_multiplier.sv | 140 ++++++++++++++
 tb/tb_iterative_multiplier.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: shift-add multiplier, one multiplier bit per RUN cycle.
// Optional two's-complement mode (Signed port) when MULT_SIGNED_EN is defined.
`default_nettype none

module iterative_multiplier #(
  parameter int WID_DATA = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [WID_DATA-1:0] OperandA,
  input  logic [WID_DATA-1:0] OperandB,
`ifdef MULT_SIGNED_EN
  input  logic                Signed,
`endif
  output logic                Busy,
  output logic                Done,
  output logic                Stall,
  output logic [WID_DATA-1:0] ProductHi,
  output logic [WID_DATA-1:0] ProductLo
);

  localparam int                c_CNT_W = (WID_DATA > 2) ? $clog2(WID_DATA) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WID_DATA - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_accept;
  logic                    w_last;

  logic [c_CNT_W-1:0]      r_cnt;
  logic [WID_DATA-1:0]     r_mcand;
  logic [WID_DATA-1:0]     r_mplier;
  logic [WID_DATA-1:0]     r_acc;
  logic                    r_neg;

  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [WID_DATA-1:0]     w_mag_a;
  logic [WID_DATA-1:0]     w_mag_b;
  logic [WID_DATA:0]       w_addend;
  logic [WID_DATA:0]       w_sum;
  logic [2*WID_DATA-1:0]   w_raw;
  logic [2*WID_DATA-1:0]   w_res;

`ifdef MULT_SIGNED_EN
  assign w_a_neg = Signed & OperandA[WID_DATA-1];
  assign w_b_neg = Signed & OperandB[WID_DATA-1];
`else
  assign w_a_neg = 1'b0;
  assign w_b_neg = 1'b0;
`endif

  // Most-negative input negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a = w_a_neg ? (~OperandA + 1'b1) : OperandA;
  assign w_mag_b = w_b_neg ? (~OperandB + 1'b1) : OperandB;

  assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);
  assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = {1'b0, r_acc} + w_addend;
  assign w_raw    = {w_sum, r_mplier[WID_DATA-1:1]};
  assign w_res    = r_neg ? (~w_raw + 1'b1) : w_raw;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        Busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign Stall = w_accept | Busy;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      ProductHi <= '0;
      ProductLo <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_mcand  <= w_mag_a;
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_neg    <= w_a_neg ^ w_b_neg;
    end else if (r_state == S_RUN) begin
      // {carry, acc, multiplier} shifts right; the product ends up in {acc, multiplier}.
      r_acc    <= w_sum[WID_DATA:1];
      r_mplier <= {w_sum[0], r_mplier[WID_DATA-1:1]};
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        ProductHi <= w_res[2*WID_DATA-1:WID_DATA];
        ProductLo <= w_res[WID_DATA-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: directed vectors with hand-computed products for WID_DATA=32.
`default_nettype none

module tb_iterative_multiplier;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Signed;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] ProductHi;
  logic [31:0] ProductLo;

  int n_checks;
  int n_fail;

  iterative_multiplier #(.WID_DATA(32)) u_dut (
    .Clock    (clk),
    .Reset    (Reset),
    .Start    (Start),
    .OperandA (OperandA),
    .OperandB (OperandB),
`ifdef MULT_SIGNED_EN
    .Signed   (Signed),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall),
    .ProductHi(ProductHi),
    .ProductLo(ProductLo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    OperandA = a;
    OperandB = b;
    Signed   = s;
    Start    = 1'b1;
    tick();
    Start    = 1'b0;
  endtask

  // Called one cycle after the Start cycle; returns the cycle index of Done.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!Done && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!Done) check_val("done_timeout", 64'(Done), 64'd1);
  endtask

  initial begin
    int cyc;
    int stalls;
    int pulses;
    logic [31:0] lo_seen;

    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    OperandA = '0;
    OperandB = '0;
    Signed   = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;

    check_val("rst_busy",  64'(Busy), 64'd0);
    check_val("rst_done",  64'(Done), 64'd0);
    check_val("rst_stall", 64'(Stall), 64'd0);
    check_val("rst_hi",    64'(ProductHi), 64'd0);
    check_val("rst_lo",    64'(ProductLo), 64'd0);

    // 3*5: latency and Stall width
    OperandA = 32'd3;
    OperandB = 32'd5;
    Start    = 1'b1;
    #1;
    check_val("stall_start", 64'(Stall), 64'd1);
    tick();
    Start    = 1'b0;
    OperandA = '0;
    OperandB = '0;
    check_val("busy_run", 64'(Busy), 64'd1);
    cyc    = 1;
    stalls = 1;
    while (!Done && cyc < 100) begin
      if (Stall) stalls++;
      tick();
      cyc++;
    end
    check_val("lat_3x5",     64'(cyc), 64'd33);
    check_val("stall_width", 64'(stalls), 64'd33);
    check_val("hi_3x5",      64'(ProductHi), 64'h0);
    check_val("lo_3x5",      64'(ProductLo), 64'hF);
    check_val("stall_done",  64'(Stall), 64'd0);
    check_val("busy_done",   64'(Busy), 64'd0);
    tick();
    check_val("done_single", 64'(Done), 64'd0);
    check_val("stall_idle",  64'(Stall), 64'd0);
    check_val("lo_held",     64'(ProductLo), 64'hF);

    // all-ones operands, then back-to-back 2*4 accepted in DONE
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc);
    check_val("lat_ff",  64'(cyc), 64'd33);
    check_val("hi_ff",   64'(ProductHi), 64'hFFFF_FFFE);
    check_val("lo_ff",   64'(ProductLo), 64'h1);
    OperandA = 32'd2;
    OperandB = 32'd4;
    Start    = 1'b1;
    #1;
    check_val("stall_b2b", 64'(Stall), 64'd1);
    tick();
    Start = 1'b0;
    check_val("busy_b2b", 64'(Busy), 64'd1);
    check_val("done_b2b", 64'(Done), 64'd0);
    wait_done(cyc);
    check_val("lat_b2b", 64'(cyc), 64'd33);
    check_val("hi_2x4",  64'(ProductHi), 64'h0);
    check_val("lo_2x4",  64'(ProductLo), 64'h8);
    tick();

    // Start mid-RUN is ignored
    start_op(32'd3, 32'd5, 1'b0);
    repeat (5) tick();
    OperandA = 32'd7;
    OperandB = 32'd7;
    Start    = 1'b1;
    tick();
    Start   = 1'b0;
    pulses  = 0;
    lo_seen = '0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        pulses++;
        lo_seen = ProductLo;
      end
      tick();
    end
    check_val("midrun_pulses", 64'(pulses), 64'd1);
    check_val("midrun_lo",     64'(lo_seen), 64'hF);

    // Reset in RUN cycle 10 abandons the operation
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) tick();
    check_val("busy_c10", 64'(Busy), 64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("rr_busy",  64'(Busy), 64'd0);
    check_val("rr_done",  64'(Done), 64'd0);
    check_val("rr_stall", 64'(Stall), 64'd0);
    check_val("rr_hi",    64'(ProductHi), 64'h0);
    check_val("rr_lo",    64'(ProductLo), 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) pulses++;
      tick();
    end
    check_val("rr_no_done", 64'(pulses), 64'd0);

`ifdef MULT_SIGNED_EN
    start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(cyc);
    check_val("s_hi_m3x5", 64'(ProductHi), 64'hFFFF_FFFF);
    check_val("s_lo_m3x5", 64'(ProductLo), 64'hFFFF_FFF1);
    check_val("s_lat",     64'(cyc), 64'd33);
    tick();
    start_op(32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_done(cyc);
    check_val("u_hi_m3x5", 64'(ProductHi), 64'h4);
    check_val("u_lo_m3x5", 64'(ProductLo), 64'hFFFF_FFF1);
    tick();
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(cyc);
    check_val("s_hi_minmin", 64'(ProductHi), 64'h4000_0000);
    check_val("s_lo_minmin", 64'(ProductLo), 64'h0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
